// File: rtl/reg_file_pkg.sv
// Shared register-file types. The global widths normally come from head.v;
// they are provided here (guarded) so this slice builds on its own.
// Optional feature macro: RF_CMT_BYPASS_EN (commit-to-read bypass).
`ifndef REG_BIT
`define REG_BIT 5
`endif
`ifndef ROB_BIT
`define ROB_BIT 5
`endif
`ifndef DAT_W
`define DAT_W 32
`endif
`ifndef REG_S
`define REG_S 32
`endif

package reg_file_pkg;

  typedef logic [`REG_BIT-1:0] reg_idx_t;
  typedef logic [`ROB_BIT-1:0] rob_tag_t;
  typedef logic [`DAT_W-1:0]   dat_t;

  // x0 is hardwired: any write or rename aimed at it is dropped.
  function automatic logic is_live_rd(input reg_idx_t rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// rf_read_port: combinational operand resolve for one source register.
// Priority: x0, committed value, commit bypass (RF_CMT_BYPASS_EN only),
// ROB ready value, otherwise the pending producer tag.
module rf_read_port
  import reg_file_pkg::*;
(
  input  logic [`REG_BIT-1:0] rs_i,
  input  logic [`ROB_BIT-1:0] tag_i,
  input  logic [`DAT_W-1:0]   val_i,
  input  logic                rob_rdy_i,
  input  logic [`DAT_W-1:0]   rob_rdyv_i,
  input  logic                cmt_en_i,
  input  logic [`REG_BIT-1:0] cmt_rd_i,
  input  logic [`ROB_BIT-1:0] cmt_q_i,
  input  logic [`DAT_W-1:0]   cmt_v_i,
  output logic [`ROB_BIT-1:0] q_o,
  output logic [`DAT_W-1:0]   v_o
);

`ifndef RF_CMT_BYPASS_EN
  // Commit inputs only matter when the bypass is built in.
  logic unused_cmt;
  assign unused_cmt = ^{cmt_en_i, cmt_rd_i, cmt_q_i, cmt_v_i};
`endif

  // Resolve the operand; value is forced to 0 whenever a tag is returned.
  always_comb begin
    q_o = '0;
    v_o = '0;
    if (rs_i != '0) begin
      if (tag_i == '0) begin
        v_o = val_i;
      end
`ifdef RF_CMT_BYPASS_EN
      else if (cmt_en_i && (cmt_rd_i == rs_i) && (tag_i == cmt_q_i)) begin
        v_o = cmt_v_i;
      end
`endif
      else if (rob_rdy_i) begin
        v_o = rob_rdyv_i;
      end else begin
        q_o = tag_i;
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: architectural register file with rename tags for a
// Tomasulo/ROB core. Two combinational read ports, one issue (rename)
// write and one commit write per cycle; branch flush clears every tag.
// Optional feature macro: RF_CMT_BYPASS_EN (same-cycle commit bypass on reads).
module reg_file
  import reg_file_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                br_flag_i,
  input  logic                is_en_i,
  input  logic [`REG_BIT-1:0] is_rd_i,
  input  logic [`ROB_BIT-1:0] is_q_i,
  input  logic [`REG_BIT-1:0] is_rs1_i,
  input  logic [`REG_BIT-1:0] is_rs2_i,
  output logic [`ROB_BIT-1:0] qj_o,
  output logic [`ROB_BIT-1:0] qk_o,
  output logic [`DAT_W-1:0]   vj_o,
  output logic [`DAT_W-1:0]   vk_o,
  output logic [`ROB_BIT-1:0] rob_reqqj_o,
  output logic [`ROB_BIT-1:0] rob_reqqk_o,
  input  logic                rob_rdyj_i,
  input  logic                rob_rdyk_i,
  input  logic [`DAT_W-1:0]   rob_rdyvj_i,
  input  logic [`DAT_W-1:0]   rob_rdyvk_i,
  input  logic                cmt_en_i,
  input  logic [`REG_BIT-1:0] cmt_rd_i,
  input  logic [`ROB_BIT-1:0] cmt_q_i,
  input  logic [`DAT_W-1:0]   cmt_v_i
);

  dat_t     val_q [`REG_S];
  dat_t     val_d [`REG_S];
  rob_tag_t tag_q [`REG_S];
  rob_tag_t tag_d [`REG_S];

  // Next state: commit writes value and retires a matching tag; a flush
  // then wipes all tags (dropping any issue), else issue renames rd.
  // Issue is applied after the commit clear so a same-rd rename survives.
  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (en) begin
      if (cmt_en_i && is_live_rd(cmt_rd_i)) begin
        val_d[cmt_rd_i] = cmt_v_i;
        if (tag_q[cmt_rd_i] == cmt_q_i) begin
          tag_d[cmt_rd_i] = '0;
        end
      end
      if (br_flag_i) begin
        for (int i = 0; i < `REG_S; i++) begin
          tag_d[i] = '0;
        end
      end else if (is_en_i && is_live_rd(is_rd_i)) begin
        tag_d[is_rd_i] = is_q_i;
      end
    end
  end

  // State registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < `REG_S; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  // ROB lookup requests use the pre-edge tags; entry 0 is never written,
  // so x0 always requests tag 0.
  assign rob_reqqj_o = tag_q[is_rs1_i];
  assign rob_reqqk_o = tag_q[is_rs2_i];

  rf_read_port u_port_j (
    .rs_i       (is_rs1_i),
    .tag_i      (tag_q[is_rs1_i]),
    .val_i      (val_q[is_rs1_i]),
    .rob_rdy_i  (rob_rdyj_i),
    .rob_rdyv_i (rob_rdyvj_i),
    .cmt_en_i   (cmt_en_i),
    .cmt_rd_i   (cmt_rd_i),
    .cmt_q_i    (cmt_q_i),
    .cmt_v_i    (cmt_v_i),
    .q_o        (qj_o),
    .v_o        (vj_o)
  );

  rf_read_port u_port_k (
    .rs_i       (is_rs2_i),
    .tag_i      (tag_q[is_rs2_i]),
    .val_i      (val_q[is_rs2_i]),
    .rob_rdy_i  (rob_rdyk_i),
    .rob_rdyv_i (rob_rdyvk_i),
    .cmt_en_i   (cmt_en_i),
    .cmt_rd_i   (cmt_rd_i),
    .cmt_q_i    (cmt_q_i),
    .cmt_v_i    (cmt_v_i),
    .q_o        (qk_o),
    .v_o        (vk_o)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file. The driver sets inputs just
// after each rising edge, pushes the expected read-port tuple computed from
// a behavioural register/tag model, then advances the model. A monitor on
// the falling edge pops and compares against the DUT outputs.
`ifndef REG_BIT
`define REG_BIT 5
`endif
`ifndef ROB_BIT
`define ROB_BIT 5
`endif
`ifndef DAT_W
`define DAT_W 32
`endif
`ifndef REG_S
`define REG_S 32
`endif

module tb_reg_file;

  localparam int EXP_W = 2 * (`ROB_BIT + `DAT_W) + 2 * `ROB_BIT;

  logic                clk;
  logic                rst;
  logic                en;
  logic                br_flag_i;
  logic                is_en_i;
  logic [`REG_BIT-1:0] is_rd_i;
  logic [`ROB_BIT-1:0] is_q_i;
  logic [`REG_BIT-1:0] is_rs1_i;
  logic [`REG_BIT-1:0] is_rs2_i;
  logic [`ROB_BIT-1:0] qj_o;
  logic [`ROB_BIT-1:0] qk_o;
  logic [`DAT_W-1:0]   vj_o;
  logic [`DAT_W-1:0]   vk_o;
  logic [`ROB_BIT-1:0] rob_reqqj_o;
  logic [`ROB_BIT-1:0] rob_reqqk_o;
  logic                rob_rdyj_i;
  logic                rob_rdyk_i;
  logic [`DAT_W-1:0]   rob_rdyvj_i;
  logic [`DAT_W-1:0]   rob_rdyvk_i;
  logic                cmt_en_i;
  logic [`REG_BIT-1:0] cmt_rd_i;
  logic [`ROB_BIT-1:0] cmt_q_i;
  logic [`DAT_W-1:0]   cmt_v_i;

  logic [EXP_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [`DAT_W-1:0]   mval [`REG_S];
  logic [`ROB_BIT-1:0] mtag [`REG_S];

  reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .br_flag_i   (br_flag_i),
    .is_en_i     (is_en_i),
    .is_rd_i     (is_rd_i),
    .is_q_i      (is_q_i),
    .is_rs1_i    (is_rs1_i),
    .is_rs2_i    (is_rs2_i),
    .qj_o        (qj_o),
    .qk_o        (qk_o),
    .vj_o        (vj_o),
    .vk_o        (vk_o),
    .rob_reqqj_o (rob_reqqj_o),
    .rob_reqqk_o (rob_reqqk_o),
    .rob_rdyj_i  (rob_rdyj_i),
    .rob_rdyk_i  (rob_rdyk_i),
    .rob_rdyvj_i (rob_rdyvj_i),
    .rob_rdyvk_i (rob_rdyvk_i),
    .cmt_en_i    (cmt_en_i),
    .cmt_rd_i    (cmt_rd_i),
    .cmt_q_i     (cmt_q_i),
    .cmt_v_i     (cmt_v_i)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {q, v} for one read port from the model's current contents
  function automatic logic [`ROB_BIT+`DAT_W-1:0] ref_read(
    input logic [`REG_BIT-1:0] rs,
    input logic                rdy,
    input logic [`DAT_W-1:0]   rdyv
  );
    if (rs == 0) return '0;
    if (mtag[rs] == 0) return {{`ROB_BIT{1'b0}}, mval[rs]};
`ifdef RF_CMT_BYPASS_EN
    if (cmt_en_i && cmt_rd_i == rs && mtag[rs] == cmt_q_i)
      return {{`ROB_BIT{1'b0}}, cmt_v_i};
`endif
    if (rdy) return {{`ROB_BIT{1'b0}}, rdyv};
    return {mtag[rs], {`DAT_W{1'b0}}};
  endfunction

  // Advance the model by one clock edge using the current inputs
  task automatic model_step();
    logic clr;
    if (rst) begin
      for (int i = 0; i < `REG_S; i++) begin
        mval[i] = '0;
        mtag[i] = '0;
      end
    end else if (en) begin
      clr = cmt_en_i && cmt_rd_i != 0 && mtag[cmt_rd_i] == cmt_q_i;
      if (cmt_en_i && cmt_rd_i != 0) mval[cmt_rd_i] = cmt_v_i;
      if (clr) mtag[cmt_rd_i] = '0;
      if (br_flag_i) begin
        for (int i = 0; i < `REG_S; i++) mtag[i] = '0;
      end else if (is_en_i && is_rd_i != 0) begin
        mtag[is_rd_i] = is_q_i;
      end
    end
  endtask

  // Driver: inputs are already applied; record expectation, step model, clock
  task automatic run_cycle();
    logic [`ROB_BIT+`DAT_W-1:0] pj;
    logic [`ROB_BIT+`DAT_W-1:0] pk;
    pj = ref_read(is_rs1_i, rob_rdyj_i, rob_rdyvj_i);
    pk = ref_read(is_rs2_i, rob_rdyk_i, rob_rdyvk_i);
    exp_q.push_back({pj, pk, mtag[is_rs1_i], mtag[is_rs2_i]});
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; en = 1'b1; br_flag_i = 1'b0;
    is_en_i = 1'b0; is_rd_i = '0; is_q_i = '0; is_rs1_i = '0; is_rs2_i = '0;
    rob_rdyj_i = 1'b0; rob_rdyk_i = 1'b0; rob_rdyvj_i = '0; rob_rdyvk_i = '0;
    cmt_en_i = 1'b0; cmt_rd_i = '0; cmt_q_i = '0; cmt_v_i = '0;
  endtask

  task automatic do_issue(input int rd, input int q);
    is_en_i = 1'b1; is_rd_i = `REG_BIT'(rd); is_q_i = `ROB_BIT'(q);
  endtask

  task automatic do_commit(input int rd, input int q, input logic [`DAT_W-1:0] v);
    cmt_en_i = 1'b1; cmt_rd_i = `REG_BIT'(rd); cmt_q_i = `ROB_BIT'(q); cmt_v_i = v;
  endtask

  task automatic do_read(input int rs1, input int rs2);
    is_rs1_i = `REG_BIT'(rs1); is_rs2_i = `REG_BIT'(rs2);
  endtask

  // Monitor / scoreboard: compare on the falling edge, away from updates
  always @(negedge clk) begin
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {qj_o, vj_o, qk_o, vk_o, rob_reqqj_o, rob_reqqk_o};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL read_ports t=%0t rs1=%0d rs2=%0d actual qj=%0d vj=%h qk=%0d vk=%h reqj=%0d reqk=%0d required qj=%0d vj=%h qk=%0d vk=%h reqj=%0d reqk=%0d",
                 $time, is_rs1_i, is_rs2_i,
                 qj_o, vj_o, qk_o, vk_o, rob_reqqj_o, rob_reqqk_o,
                 exp_v[EXP_W-1 -: `ROB_BIT],
                 exp_v[EXP_W-`ROB_BIT-1 -: `DAT_W],
                 exp_v[2*`ROB_BIT+`DAT_W+`ROB_BIT-1 -: `ROB_BIT],
                 exp_v[2*`ROB_BIT+`DAT_W-1 -: `DAT_W],
                 exp_v[2*`ROB_BIT-1 -: `ROB_BIT],
                 exp_v[`ROB_BIT-1:0]);
      end
    end
  end

  // Stimulus
  initial begin
    int rd;
    idle();
    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < `REG_S; i++) begin
      mval[i] = '0;
      mtag[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    idle();

    // Post-reset reads of x5/x6
    do_read(5, 6); run_cycle();

    // Rename x3 -> 7, then read with and without a ready ROB entry
    idle(); do_issue(3, 7); run_cycle();
    idle(); do_read(3, 0); run_cycle();
    idle(); do_read(3, 3); rob_rdyj_i = 1'b1; rob_rdyvj_i = 32'hAB; run_cycle();

    // Younger rename survives an older commit; matching commit clears
    idle(); do_issue(3, 9); do_read(3, 3); run_cycle();
    idle(); do_commit(3, 7, 32'h11); do_read(3, 3); run_cycle();
    idle(); do_read(3, 3); run_cycle();
    idle(); do_commit(3, 9, 32'h22); run_cycle();
    idle(); do_read(3, 3); run_cycle();

    // Same-cycle issue and commit to x4: issue wins the tag
    idle(); do_issue(4, 12); do_commit(4, 2, 32'h55); run_cycle();
    idle(); do_read(4, 4); rob_rdyk_i = 1'b1; rob_rdyvk_i = 32'h99; run_cycle();
    idle(); do_commit(4, 12, 32'h66); run_cycle();
    idle(); do_read(4, 0); run_cycle();

    // Flush with commit and a discarded issue
    idle(); do_issue(1, 5); run_cycle();
    idle(); do_issue(2, 6); do_read(1, 2); run_cycle();
    idle(); br_flag_i = 1'b1; do_commit(1, 5, 32'h80); do_issue(7, 3); run_cycle();
    idle(); do_read(1, 2); run_cycle();
    idle(); do_read(7, 7); run_cycle();

    // Commit bypass case on port k (macro dependent in the model)
    idle(); do_issue(8, 6); run_cycle();
    idle(); do_commit(8, 6, 32'hCAFE); do_read(0, 8); run_cycle();
    idle(); do_read(8, 8); run_cycle();

    // Enable low: nothing is written, reads still work
    idle(); en = 1'b0; do_issue(9, 4); do_commit(10, 0, 32'h1234); do_read(9, 10); run_cycle();
    idle(); do_read(9, 10); run_cycle();

    // x0 ignores rename and write
    idle(); do_issue(0, 3); do_commit(0, 0, 32'hDEAD); run_cycle();
    idle(); do_read(0, 0); rob_rdyj_i = 1'b1; rob_rdyvj_i = 32'h7; run_cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      en          = ($urandom_range(0, 9) != 0);
      br_flag_i   = ($urandom_range(0, 29) == 0);
      is_en_i     = ($urandom_range(0, 1) == 1);
      is_rd_i     = `REG_BIT'($urandom_range(0, `REG_S-1));
      is_q_i      = `ROB_BIT'($urandom_range(1, (1 << `ROB_BIT) - 1));
      is_rs1_i    = `REG_BIT'($urandom_range(0, `REG_S-1));
      is_rs2_i    = ($urandom_range(0, 3) == 0) ? cmt_rd_i : `REG_BIT'($urandom_range(0, `REG_S-1));
      rob_rdyj_i  = ($urandom_range(0, 2) == 0);
      rob_rdyk_i  = ($urandom_range(0, 2) == 0);
      rob_rdyvj_i = $urandom;
      rob_rdyvk_i = $urandom;
      cmt_en_i    = ($urandom_range(0, 1) == 1);
      rd          = $urandom_range(0, `REG_S-1);
      cmt_rd_i    = `REG_BIT'(rd);
      cmt_q_i     = ($urandom_range(0, 1) == 1 && mtag[rd] != 0) ? mtag[rd]
                    : `ROB_BIT'($urandom_range(1, (1 << `ROB_BIT) - 1));
      cmt_v_i     = $urandom;
      if ($urandom_range(0, 2) == 0) is_rs1_i = cmt_rd_i;
      run_cycle();
    end

    // Reset in the middle of traffic, then sweep every index
    idle(); rst = 1'b1; do_issue(5, 5); do_commit(6, 1, 32'h3); br_flag_i = 1'b1; run_cycle();
    for (int i = 0; i < `REG_S; i++) begin
      idle(); do_read(i, `REG_S - 1 - i); run_cycle();
    end

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: actual %0d entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
